// File: rtl/resize_coord_gen_pkg.sv
// Shared constants and types for the resize coordinate generator:
// default widths, the control FSM state encoding and Q-format helpers.
package resize_coord_gen_pkg;

    // Default width of image dimensions and integer source coordinates.
    localparam int DIM_W_DEF  = 16;
    // Default number of fractional bits in scale factors and weights.
    localparam int FRAC_W_DEF = 8;

    // Unity in the unsigned Q(DIM_W).(FRAC_W) format (1 << FRAC_W).
    localparam logic [FRAC_W_DEF:0] Q_ONE = {1'b1, {FRAC_W_DEF{1'b0}}};

    // Frame-level control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : resize_coord_gen_pkg

// File: rtl/resize_coord_gen_if.sv
// Output beat bus of the coordinate generator towards the weight
// multipliers. The master owns the beat payload and o_valid, the slave
// owns o_ready (which doubles as the multiplier clock enable).
interface resize_coord_gen_if #(
    parameter int DIM_W  = resize_coord_gen_pkg::DIM_W_DEF,
    parameter int FRAC_W = resize_coord_gen_pkg::FRAC_W_DEF
);

    logic              o_valid;
    logic              o_ready;
    logic [DIM_W-1:0]  o_src_x;
    logic [DIM_W-1:0]  o_src_y;
    logic [FRAC_W-1:0] o_fx;
    logic [FRAC_W-1:0] o_fy;
    logic              o_eol;
    logic              o_eof;

    modport master (
        output o_valid,
        output o_src_x,
        output o_src_y,
        output o_fx,
        output o_fy,
        output o_eol,
        output o_eof,
        input  o_ready
    );

    modport slave (
        input  o_valid,
        input  o_src_x,
        input  o_src_y,
        input  o_fx,
        input  o_fy,
        input  o_eol,
        input  o_eof,
        output o_ready
    );

endinterface : resize_coord_gen_if

// File: rtl/resize_coord_gen_axis.sv
// One axis of the coordinate walk: an output-position counter and a
// saturating fixed-point accumulator that steps by the scale factor.
// When the counter sits on the last output index the next advance wraps
// both back to zero. The accumulator is split into integer source
// coordinate and fractional weight, clamped to the source extent.
module resize_coord_gen_axis
    import resize_coord_gen_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,      // restart the walk at position 0
    input  logic                    adv_i,      // step to the next output position
    input  logic [DIM_W+FRAC_W-1:0] scale_i,    // source step per output pixel
    input  logic [DIM_W-1:0]        last_i,     // last output index (out - 1)
    input  logic [DIM_W-1:0]        lim_i,      // last source index (in - 1)
    output logic                    at_last_o,  // counter is on the last index
    output logic [DIM_W-1:0]        src_o,      // clamped integer source coord
    output logic [FRAC_W-1:0]       frac_o      // weight, zero when clamped
);

    localparam int ACC_W = DIM_W + FRAC_W + 1;

    localparam logic [DIM_W-1:0] CNT_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [DIM_W-1:0] cnt_q;
    logic [DIM_W-1:0] cnt_d;
    logic [ACC_W:0]   sum_s;
    logic [DIM_W:0]   int_s;

    // Next counter/accumulator value: clear, wrap at row end, or step with saturation.
    always_comb begin
        sum_s     = {1'b0, acc_q} + {2'b00, scale_i};
        at_last_o = (cnt_q == last_i);
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        if (clr_i) begin
            cnt_d = {DIM_W{1'b0}};
            acc_d = {ACC_W{1'b0}};
        end else if (adv_i) begin
            if (at_last_o) begin
                cnt_d = {DIM_W{1'b0}};
                acc_d = {ACC_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                acc_d = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
            end
        end else begin
            cnt_d = cnt_q;
            acc_d = acc_q;
        end
    end

    // Split the accumulator into source index and weight, clamping past the source edge.
    always_comb begin
        int_s = acc_q[ACC_W-1:FRAC_W];
        if (int_s > {1'b0, lim_i}) begin
            src_o  = lim_i;
            frac_o = {FRAC_W{1'b0}};
        end else begin
            src_o  = int_s[DIM_W-1:0];
            frac_o = acc_q[FRAC_W-1:0];
        end
    end

    // Walk state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {DIM_W{1'b0}};
            acc_q <= {ACC_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule : resize_coord_gen_axis

// File: rtl/resize_coord_gen.sv
// Resize coordinate generator. Walks the destination raster row by row and
// emits, per output pixel, the clamped integer source coordinate and the
// fractional weight on both axes through a single output register with a
// valid/ready handshake. Holds the frame FSM and the latched configuration.
module resize_coord_gen
    import resize_coord_gen_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DIM_W-1:0]        in_w,
    input  logic [DIM_W-1:0]        in_h,
    input  logic [DIM_W-1:0]        out_w,
    input  logic [DIM_W-1:0]        out_h,
    input  logic [DIM_W+FRAC_W-1:0] scale_x,
    input  logic [DIM_W+FRAC_W-1:0] scale_y,
    output logic                    busy,
    output logic                    done,
    resize_coord_gen_if.master      out_if
);

    localparam logic [DIM_W-1:0] DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};

    // Frame control
    state_e state_q;
    logic   busy_q;
    logic   done_q;
    logic   last_loaded_q;   // eof beat already sits in the output register

    // Latched configuration, stored as last indices
    logic [DIM_W-1:0]        lim_x_q;
    logic [DIM_W-1:0]        lim_y_q;
    logic [DIM_W-1:0]        last_x_q;
    logic [DIM_W-1:0]        last_y_q;
    logic [DIM_W+FRAC_W-1:0] scale_x_q;
    logic [DIM_W+FRAC_W-1:0] scale_y_q;

    // Output register
    logic              valid_q;
    logic [DIM_W-1:0]  src_x_q;
    logic [DIM_W-1:0]  src_y_q;
    logic [FRAC_W-1:0] fx_q;
    logic [FRAC_W-1:0] fy_q;
    logic              eol_q;
    logic              eof_q;

    // Generator view
    logic              start_acc_s;
    logic              empty_s;
    logic              load_s;
    logic              eof_acc_s;
    logic              x_last_s;
    logic              y_last_s;
    logic              y_adv_s;
    logic [DIM_W-1:0]  gen_src_x_s;
    logic [DIM_W-1:0]  gen_src_y_s;
    logic [FRAC_W-1:0] gen_fx_s;
    logic [FRAC_W-1:0] gen_fy_s;

    // Handshake decode: start acceptance, output-register load and eof acceptance.
    always_comb begin
        start_acc_s = (state_q == ST_IDLE) && start;
        empty_s     = (out_w == DIM_ZERO) || (out_h == DIM_ZERO);
        load_s      = (state_q == ST_RUN) && !last_loaded_q && (!valid_q || out_if.o_ready);
        eof_acc_s   = (state_q == ST_RUN) && valid_q && out_if.o_ready && eof_q;
        y_adv_s     = load_s && x_last_s;
    end

    resize_coord_gen_axis #(
        .DIM_W  (DIM_W),
        .FRAC_W (FRAC_W)
    ) u_axis_x (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (start_acc_s),
        .adv_i     (load_s),
        .scale_i   (scale_x_q),
        .last_i    (last_x_q),
        .lim_i     (lim_x_q),
        .at_last_o (x_last_s),
        .src_o     (gen_src_x_s),
        .frac_o    (gen_fx_s)
    );

    resize_coord_gen_axis #(
        .DIM_W  (DIM_W),
        .FRAC_W (FRAC_W)
    ) u_axis_y (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (start_acc_s),
        .adv_i     (y_adv_s),
        .scale_i   (scale_y_q),
        .last_i    (last_y_q),
        .lim_i     (lim_y_q),
        .at_last_o (y_last_s),
        .src_o     (gen_src_y_s),
        .frac_o    (gen_fy_s)
    );

    // Frame FSM with registered busy/done; an empty raster goes straight to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            last_loaded_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    last_loaded_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (empty_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (load_s && x_last_s && y_last_s) begin
                        last_loaded_q <= 1'b1;
                    end else begin
                        last_loaded_q <= last_loaded_q;
                    end
                    if (eof_acc_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    last_loaded_q <= 1'b0;
                end
            endcase
        end
    end

    // Configuration latch, loaded only when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lim_x_q   <= DIM_ZERO;
            lim_y_q   <= DIM_ZERO;
            last_x_q  <= DIM_ZERO;
            last_y_q  <= DIM_ZERO;
            scale_x_q <= {(DIM_W+FRAC_W){1'b0}};
            scale_y_q <= {(DIM_W+FRAC_W){1'b0}};
        end else if (start_acc_s) begin
            lim_x_q   <= in_w - DIM_ONE;
            lim_y_q   <= in_h - DIM_ONE;
            last_x_q  <= out_w - DIM_ONE;
            last_y_q  <= out_h - DIM_ONE;
            scale_x_q <= scale_x;
            scale_y_q <= scale_y;
        end else begin
            lim_x_q   <= lim_x_q;
            lim_y_q   <= lim_y_q;
            last_x_q  <= last_x_q;
            last_y_q  <= last_y_q;
            scale_x_q <= scale_x_q;
            scale_y_q <= scale_y_q;
        end
    end

    // Output register: loads a new beat when empty or consumed, holds under stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            src_x_q <= DIM_ZERO;
            src_y_q <= DIM_ZERO;
            fx_q    <= {FRAC_W{1'b0}};
            fy_q    <= {FRAC_W{1'b0}};
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (load_s) begin
            valid_q <= 1'b1;
            src_x_q <= gen_src_x_s;
            src_y_q <= gen_src_y_s;
            fx_q    <= gen_fx_s;
            fy_q    <= gen_fy_s;
            eol_q   <= x_last_s;
            eof_q   <= x_last_s && y_last_s;
        end else if (valid_q && out_if.o_ready) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign out_if.o_valid = valid_q;
    assign out_if.o_src_x = src_x_q;
    assign out_if.o_src_y = src_y_q;
    assign out_if.o_fx    = fx_q;
    assign out_if.o_fy    = fy_q;
    assign out_if.o_eol   = eol_q;
    assign out_if.o_eof   = eof_q;

endmodule : resize_coord_gen
